uart_baud_gen_frac: RTL and testbench

UART_BAUD_GEN_FRAC -- requirements
Module: uart_baud_gen_frac

---
 rtl/uart_baud_gen_frac.sv | 136 +++++++++++++
 tb/tb_uart_baud_gen_frac.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N baud generator. Produces an oversample tick whose period
// alternates between a_int and a_int+1 clock cycles so that the mean period
// is a_int + a_frac/2^FRAC_W. Bit-period and bit-centre ticks are derived
// from the oversample tick count. A new divisor is staged and applied only
// at a period boundary, on a sync, or while the generator is idle.
module uart_baud_gen_frac #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sync,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              baud_tick,
    output logic              cfg_pending,
    output logic              cfg_err
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);

    // Reset divisor, computed in 64 bits so CLOCK_FREQ * 2^FRAC_W cannot overflow.
    localparam logic [63:0] TICK_HZ = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
    localparam logic [63:0] SCALED  = (64'(CLOCK_FREQ) << FRAC_W) / TICK_HZ;
    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(64'(CLOCK_FREQ) / TICK_HZ);
    localparam logic [FRAC_W-1:0] RST_FRAC = SCALED[FRAC_W-1:0];

    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    // Active and staged divisor.
    logic [DIV_W-1:0]  a_int;
    logic [FRAC_W-1:0] a_frac;
    logic [DIV_W-1:0]  p_int;
    logic [FRAC_W-1:0] p_frac;

    // Period generation state.
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [OS_W-1:0]   os_cnt;

    logic [DIV_W:0]    limit;
    logic [FRAC_W:0]   frac_sum;
    logic              wrap;
    logic              tick_now;
    logic              load_ok;
    logic              apply;

    // Terminal count for the current period: one extra cycle when the
    // previous wrap overflowed the fractional accumulator.
    assign limit    = {1'b0, a_int} - {{DIV_W{1'b0}}, 1'b1} + {{DIV_W{1'b0}}, carry};
    assign frac_sum = {1'b0, acc} + {1'b0, a_frac};

    // >= rather than == so a count left above a freshly shrunk limit
    // (divisor applied while idle) still wraps instead of running away.
    assign wrap     = enable && ({1'b0, cnt} >= limit);
    assign tick_now = wrap && !sync;
    assign load_ok  = div_load && (div_int >= DIV_W'(2));
    assign apply    = cfg_pending && (wrap || sync || !enable);

    // Cycle counter, fractional accumulator, oversample counter and tick outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            os_cnt    <= '0;
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else if (sync) begin
            cnt       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            os_cnt    <= '0;
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end else if (tick_now) begin
            cnt       <= '0;
            acc       <= frac_sum[FRAC_W-1:0];
            carry     <= frac_sum[FRAC_W];
            os_cnt    <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            os_tick   <= 1'b1;
            mid_tick  <= (os_cnt == OS_MID);
            baud_tick <= (os_cnt == OS_LAST);
        end else begin
            if (enable) begin
                cnt <= cnt + DIV_W'(1);
            end
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            baud_tick <= 1'b0;
        end
    end

    // Divisor staging and application; a load coinciding with an apply
    // boundary applies the older staged value and keeps the new one staged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_int       <= RST_INT;
            a_frac      <= RST_FRAC;
            p_int       <= RST_INT;
            p_frac      <= RST_FRAC;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (apply) begin
                a_int  <= p_int;
                a_frac <= p_frac;
            end
            if (load_ok) begin
                p_int       <= div_int;
                p_frac      <= div_frac;
                cfg_pending <= 1'b1;
                cfg_err     <= 1'b0;
            end else begin
                if (apply) begin
                    cfg_pending <= 1'b0;
                end
                if (div_load) begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Self-checking bench for uart_baud_gen_frac: table of divisor settings with
// a scoreboard of expected tick intervals, plus hand-written corner sequences.
module tb_uart_baud_gen_frac;

    localparam int FRAC_MOD = 16;
    localparam int OS       = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sync;
    logic       div_load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic       os_tick;
    logic       mid_tick;
    logic       baud_tick;
    logic       cfg_pending;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;
    int stray  = 0;

    typedef struct {
        int   interval;
        logic mid;
        logic baud;
    } exp_t;

    typedef struct {
        int di;
        int df;
        int n;
        int span;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    uart_baud_gen_frac #(
        .CLOCK_FREQ(100_000_000),
        .BAUD_RATE (9600),
        .OVERSAMPLE(16),
        .DIV_W     (16),
        .FRAC_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sync       (sync),
        .div_load   (div_load),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .os_tick    (os_tick),
        .mid_tick   (mid_tick),
        .baud_tick  (baud_tick),
        .cfg_pending(cfg_pending),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=done)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until os_tick is seen; n is the number of edges taken, -1 on timeout.
    task automatic wait_tick(input int max, output int n, output logic m, output logic b);
        n = 0;
        do begin
            step();
            n++;
            if ((mid_tick || baud_tick) && !os_tick) stray++;
        end while (!os_tick && n < max);
        if (!os_tick) begin
            $display("FAIL tick_timeout: actual=none required=os_tick within %0d cycles", max);
            errors++;
            checks++;
            n = -1;
        end
        m = mid_tick;
        b = baud_tick;
    endtask

    task automatic load(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    // Model the fractional accumulator from a freshly restarted phase, queue
    // the expected intervals, then pop and compare one per observed tick.
    task automatic run_ticks(input int di, input int df, input int n, output int span);
        int   acc;
        int   cy;
        int   got;
        logic m;
        logic b;
        exp_t e;
        acc  = 0;
        cy   = 0;
        span = 0;
        for (int k = 1; k <= n; k++) begin
            e.interval = di + cy;
            e.mid      = ((k % OS) == OS / 2);
            e.baud     = ((k % OS) == 0);
            sb.push_back(e);
            acc = acc + df;
            cy  = (acc >= FRAC_MOD) ? 1 : 0;
            acc = acc % FRAC_MOD;
        end
        stray = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(di + 4, got, m, b);
            check("interval", got, e.interval);
            check("mid_baud", int'({m, b}), int'({e.mid, e.baud}));
            span += got;
        end
        check("stray_tick", stray, 0);
    endtask

    initial begin
        int   span;
        int   got;
        int   seen;
        logic m;
        logic b;

        vecs[0] = '{di: 4, df: 8,  n: 32, span: 143};
        vecs[1] = '{di: 5, df: 0,  n: 8,  span: 40};
        vecs[2] = '{di: 2, df: 15, n: 16, span: 46};
        vecs[3] = '{di: 7, df: 4,  n: 16, span: 115};
        vecs[4] = '{di: 3, df: 1,  n: 16, span: 48};

        rst_n    = 1'b0;
        enable   = 1'b0;
        sync     = 1'b0;
        div_load = 1'b0;
        div_int  = '0;
        div_frac = '0;
        repeat (3) step();
        check("reset_outputs", int'({os_tick, mid_tick, baud_tick, cfg_pending, cfg_err}), 0);

        // Default divisor 651.0: 16 ticks make one 10416-cycle bit.
        rst_n  = 1'b1;
        enable = 1'b1;
        run_ticks(651, 0, 16, span);
        check("default_span", span, 10416);

        for (int i = 0; i < 5; i++) begin
            load(vecs[i].di, vecs[i].df);
            check("load_pending", int'(cfg_pending), 1);
            check("load_err", int'(cfg_err), 0);
            do_sync();
            check("sync_applies", int'(cfg_pending), 0);
            run_ticks(vecs[i].di, vecs[i].df, vecs[i].n, span);
            check("vec_span", span, vecs[i].span);
        end

        // Enable dropped two cycles into a period of 4: counters hold.
        load(4, 0);
        do_sync();
        repeat (2) step();
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (os_tick) seen++;
        end
        check("ticks_while_idle", seen, 0);
        enable = 1'b1;
        wait_tick(10, got, m, b);
        check("resume_interval", got, 2);

        // Sync on the terminal-count cycle suppresses the tick and restarts os_cnt.
        run_ticks(4, 0, 5, span);
        repeat (3) step();
        do_sync();
        check("sync_on_wrap_tick", int'(os_tick), 0);
        run_ticks(4, 0, 16, span);

        // Rejected load keeps the period; a valid load clears the error.
        load(1, 0);
        check("bad_load_err", int'(cfg_err), 1);
        check("bad_load_pending", int'(cfg_pending), 0);
        wait_tick(10, got, m, b);
        check("bad_load_rest", got, 3);
        wait_tick(10, got, m, b);
        check("bad_load_period", got, 4);
        load(8, 0);
        check("good_load_err", int'(cfg_err), 0);
        check("good_load_pending", int'(cfg_pending), 1);
        wait_tick(10, got, m, b);
        check("good_load_rest", got, 3);
        check("applied_at_wrap", int'(cfg_pending), 0);
        wait_tick(12, got, m, b);
        check("new_period", got, 8);

        // Load A mid-period, load B exactly on the wrap: A applies, B waits.
        load(5, 0);
        repeat (6) step();
        load(3, 0);
        check("wrap_load_tick", int'(os_tick), 1);
        check("wrap_load_pending", int'(cfg_pending), 1);
        wait_tick(10, got, m, b);
        check("wrap_load_a", got, 5);
        check("wrap_load_b_applied", int'(cfg_pending), 0);
        wait_tick(10, got, m, b);
        check("wrap_load_b", got, 3);

        // Back-to-back loads: the last one wins.
        load(6, 0);
        load(9, 0);
        do_sync();
        wait_tick(14, got, m, b);
        check("last_load_wins", got, 9);

        // Asynchronous reset with a tick high and a divisor pending.
        repeat (8) step();
        load(10, 0);
        check("pre_reset_tick", int'(os_tick), 1);
        check("pre_reset_pending", int'(cfg_pending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({os_tick, mid_tick, baud_tick, cfg_pending, cfg_err}), 0);
        step();
        rst_n = 1'b1;
        wait_tick(700, got, m, b);
        check("post_reset_period", got, 651);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
